// File: rtl/ibex_multdiv_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | Module   : ibex_multdiv_issue_ctrl                                                   |
// | Purpose  : ID-side issue/response controller for the multi-cycle RV32M unit.         |
// | Option   : IBEX_MULTDIV_RESULT_CACHE_EN - replay result of an identical previous op. |
// | Revision : 1.0                                                                       |
// +--------------------------------------------------------------------------------------+
module ibex_multdiv_issue_ctrl #(
  parameter logic DataIndTiming = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_rs1_i,
  input  logic [31:0] req_rs2_i,
  input  logic [4:0]  req_rd_i,
  input  logic        flush_i,
  output logic        mult_en_o,
  output logic        div_en_o,
  output logic        mult_sel_o,
  output logic        div_sel_o,
  output logic [1:0]  operator_o,
  output logic [1:0]  signed_mode_o,
  output logic [31:0] op_a_o,
  output logic [31:0] op_b_o,
  output logic        data_ind_timing_o,
  output logic [67:0] imd_val_q_o,
  input  logic [67:0] imd_val_d_i,
  input  logic [1:0]  imd_val_we_i,
  output logic        multdiv_ready_id_o,
  input  logic [31:0] multdiv_result_i,
  input  logic        valid_i,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e      r_state, w_state_next;
  logic [2:0]  r_funct3;
  logic [31:0] r_op_a, r_op_b, r_result;
  logic [4:0]  r_rd;
  logic        w_accept, w_capture, w_unit_on;
  logic        w_cache_hit;
  logic [31:0] w_cache_result;

  assign req_ready_o = rst_ni & (r_state == IDLE) & ~flush_i;
  assign w_accept    = req_ready_o & req_valid_i;
  assign w_capture   = (r_state == ISSUE) & valid_i & ~flush_i;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_cache_hit ? RESP : ISSUE;
      ISSUE: begin
        if (flush_i)      w_state_next = valid_i ? IDLE : DRAIN;
        else if (valid_i) w_state_next = RESP;
      end
      // The unit cannot be abandoned mid-operation; keep it stepping until it reports done.
      DRAIN:   if (valid_i) w_state_next = IDLE;
      RESP:    if (flush_i || wb_ready_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_funct3 <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_rd     <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_funct3 <= req_funct3_i;
        r_op_a   <= req_rs1_i;
        r_op_b   <= req_rs2_i;
        r_rd     <= req_rd_i;
        if (w_cache_hit) r_result <= w_cache_result;
      end
      if (w_capture) r_result <= multdiv_result_i;
    end
  end

`ifdef IBEX_MULTDIV_RESULT_CACHE_EN
  logic        r_cache_valid;
  logic [2:0]  r_cache_funct3;
  logic [31:0] r_cache_rs1, r_cache_rs2, r_cache_result;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cache_valid  <= 1'b0;
      r_cache_funct3 <= '0;
      r_cache_rs1    <= '0;
      r_cache_rs2    <= '0;
      r_cache_result <= '0;
    end else if (w_capture) begin
      r_cache_valid  <= 1'b1;
      r_cache_funct3 <= r_funct3;
      r_cache_rs1    <= r_op_a;
      r_cache_rs2    <= r_op_b;
      r_cache_result <= multdiv_result_i;
    end
  end

  assign w_cache_hit    = r_cache_valid & (r_cache_funct3 == req_funct3_i) &
                          (r_cache_rs1 == req_rs1_i) & (r_cache_rs2 == req_rs2_i);
  assign w_cache_result = r_cache_result;
`else
  assign w_cache_hit    = 1'b0;
  assign w_cache_result = '0;
`endif

  always_comb begin
    operator_o    = 2'd0;
    signed_mode_o = 2'b00;
    case (r_funct3)
      3'b000: begin operator_o = 2'd0; signed_mode_o = 2'b00; end
      3'b001: begin operator_o = 2'd1; signed_mode_o = 2'b11; end
      3'b010: begin operator_o = 2'd1; signed_mode_o = 2'b01; end
      3'b011: begin operator_o = 2'd1; signed_mode_o = 2'b00; end
      3'b100: begin operator_o = 2'd2; signed_mode_o = 2'b11; end
      3'b101: begin operator_o = 2'd2; signed_mode_o = 2'b00; end
      3'b110: begin operator_o = 2'd3; signed_mode_o = 2'b11; end
      default: begin operator_o = 2'd3; signed_mode_o = 2'b00; end
    endcase
  end

  assign w_unit_on          = (r_state == ISSUE) || (r_state == DRAIN);
  assign mult_en_o          = w_unit_on & ~r_funct3[2];
  assign div_en_o           = w_unit_on & r_funct3[2];
  assign mult_sel_o         = mult_en_o;
  assign div_sel_o          = div_en_o;
  assign multdiv_ready_id_o = w_unit_on;
  assign op_a_o             = r_op_a;
  assign op_b_o             = r_op_b;
  assign data_ind_timing_o  = DataIndTiming;
  assign wb_valid_o         = (r_state == RESP) & ~flush_i;
  assign wb_data_o          = r_result;
  assign wb_rd_o            = r_rd;
  assign busy_o             = (r_state != IDLE);

  // Intermediate values belong to the unit; they are written whenever it asks, in any state.
  for (genvar k = 0; k < 2; k++) begin : g_imd
    logic [33:0] r_imd;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)              r_imd <= '0;
      else if (imd_val_we_i[k]) r_imd <= imd_val_d_i[34*k +: 34];
    end
    assign imd_val_q_o[34*k +: 34] = r_imd;
  end

endmodule
`default_nettype wire

// File: tb/tb_ibex_multdiv_issue_ctrl.sv
`default_nettype none
// Testbench for ibex_multdiv_issue_ctrl: behavioural RV32M unit, vector table and scoreboard.
module tb_ibex_multdiv_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_rs1_i, req_rs2_i;
  logic [4:0]  req_rd_i;
  logic        flush_i;
  logic        mult_en_o, div_en_o, mult_sel_o, div_sel_o;
  logic [1:0]  operator_o, signed_mode_o;
  logic [31:0] op_a_o, op_b_o;
  logic        data_ind_timing_o;
  logic [67:0] imd_val_q_o, imd_val_d_i;
  logic [1:0]  imd_val_we_i;
  logic        multdiv_ready_id_o;
  logic [31:0] multdiv_result_i;
  logic        valid_i;
  logic        wb_valid_o, wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  ibex_multdiv_issue_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_funct3_i(req_funct3_i),
    .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_rd_i(req_rd_i), .flush_i(flush_i),
    .mult_en_o(mult_en_o), .div_en_o(div_en_o), .mult_sel_o(mult_sel_o), .div_sel_o(div_sel_o),
    .operator_o(operator_o), .signed_mode_o(signed_mode_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
    .data_ind_timing_o(data_ind_timing_o), .imd_val_q_o(imd_val_q_o), .imd_val_d_i(imd_val_d_i),
    .imd_val_we_i(imd_val_we_i), .multdiv_ready_id_o(multdiv_ready_id_o),
    .multdiv_result_i(multdiv_result_i), .valid_i(valid_i), .wb_valid_o(wb_valid_o),
    .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .busy_o(busy_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  int unit_lat = 3;
  int ucnt = 0;
  logic [31:0] exp_q[$];
  logic [4:0]  rd_q[$];

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [1:0]  op;
    logic [1:0]  sm;
    logic [31:0] data;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural unit: works only from the controller's outputs (operator / signed mode).
  function automatic logic [31:0] unit_calc(input logic [1:0] op, input logic [1:0] sm,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, p;
    logic signed [31:0] sa, sb;
    xa = sm[0] ? {{32{a[31]}}, a} : {32'b0, a};
    xb = sm[1] ? {{32{b[31]}}, b} : {32'b0, b};
    p  = xa * xb;
    sa = a;
    sb = b;
    case (op)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
      2'd2: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        if (sm == 2'b11) begin
          if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
          return sa / sb;
        end
        return a / b;
      end
      default: begin
        if (b == 32'h0) return a;
        if (sm == 2'b11) begin
          if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
          return sa % sb;
        end
        return a % b;
      end
    endcase
  endfunction

  // Reference from the ISA's point of view (funct3 semantics).
  function automatic logic [31:0] ref_calc(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa64, sb64, ub64, ps;
    logic [63:0] pu;
    logic signed [31:0] sa, sb;
    sa = a; sb = b;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ub64 = {32'b0, b};
    case (f3)
      3'b000: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
      3'b001: begin ps = sa64 * sb64; return ps[63:32]; end
      3'b010: begin ps = sa64 * ub64; return ps[63:32]; end
      3'b011: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return sa / sb;
      end
      3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  always @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_i = 1'b0; multdiv_result_i = '0; ucnt = 0;
    end else if (mult_en_o || div_en_o) begin
      if (ucnt >= unit_lat - 1) begin
        valid_i = 1'b1;
        multdiv_result_i = unit_calc(operator_o, signed_mode_o, op_a_o, op_b_o);
        ucnt = 0;
      end else begin
        valid_i = 1'b0;
        ucnt++;
      end
    end else begin
      valid_i = 1'b0; ucnt = 0;
    end
  end

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit push, input logic [31:0] exp);
    int t;
    t = 0;
    @(negedge clk_i);
    while (!req_ready_o && t < 50) begin @(negedge clk_i); t++; end
    chk("req_ready_idle", req_ready_o, 1'b1);
    req_valid_i = 1'b1; req_funct3_i = f3; req_rs1_i = a; req_rs2_i = b; req_rd_i = rd;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    if (push) begin exp_q.push_back(exp); rd_q.push_back(rd); end
  endtask

  task automatic wait_wb();
    int t;
    t = 0;
    while (!wb_valid_o && t < 100) begin @(negedge clk_i); t++; end
    if (!wb_valid_o) begin
      n_cmp++; n_err++;
      $display("FAIL wb_timeout: got wb_valid 0 expected 1");
    end else if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL wb_unexpected: got wb_valid 1 expected 0");
    end else begin
      chk("wb_data", wb_data_o, exp_q.pop_front());
      chk("wb_rd", wb_rd_o, rd_q.pop_front());
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    bit          seen;
    int          t;

    vecs[0]  = '{3'b000, 32'd7,         32'd6,         5'd5,  2'd0, 2'b00, 32'h0000002A};
    vecs[1]  = '{3'b001, 32'h80000000,  32'h80000000,  5'd6,  2'd1, 2'b11, 32'h40000000};
    vecs[2]  = '{3'b010, 32'hFFFFFFFF,  32'd2,         5'd7,  2'd1, 2'b01, 32'hFFFFFFFF};
    vecs[3]  = '{3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd8,  2'd1, 2'b00, 32'hFFFFFFFE};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9,  32'd2,         5'd9,  2'd2, 2'b11, 32'hFFFFFFFD};
    vecs[5]  = '{3'b101, 32'h00001234,  32'd0,         5'd10, 2'd2, 2'b00, 32'hFFFFFFFF};
    vecs[6]  = '{3'b110, 32'hFFFFFFF9,  32'd2,         5'd11, 2'd3, 2'b11, 32'hFFFFFFFF};
    vecs[7]  = '{3'b111, 32'd5,         32'd0,         5'd12, 2'd3, 2'b00, 32'd5};
    vecs[8]  = '{3'b100, 32'h80000000,  32'hFFFFFFFF,  5'd13, 2'd2, 2'b11, 32'h80000000};
    vecs[9]  = '{3'b101, 32'd100,       32'd7,         5'd14, 2'd2, 2'b00, 32'd14};
    vecs[10] = '{3'b111, 32'd100,       32'd7,         5'd15, 2'd3, 2'b00, 32'd2};
    vecs[11] = '{3'b000, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd31, 2'd0, 2'b00, 32'd1};

    rst_ni = 1'b0; req_valid_i = 1'b0; req_funct3_i = '0; req_rs1_i = '0; req_rs2_i = '0;
    req_rd_i = '0; flush_i = 1'b0; imd_val_d_i = '0; imd_val_we_i = '0; wb_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_req_ready", req_ready_o, 1'b0);
    chk("rst_en", {mult_en_o, div_en_o, mult_sel_o, div_sel_o, multdiv_ready_id_o}, 5'b0);
    chk("rst_op", {operator_o, signed_mode_o, op_a_o, op_b_o}, 68'h0);
    chk("rst_imd", imd_val_q_o, 68'h0);
    chk("rst_wb", {wb_valid_o, wb_rd_o, wb_data_o}, 38'h0);
    chk("rst_dit", data_ind_timing_o, 1'b0);
    rst_ni = 1'b1;

    // Table: decode, unit handshake and writeback per op.
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b1, vecs[i].data);
      chk("operator", operator_o, vecs[i].op);
      chk("signed_mode", signed_mode_o, vecs[i].sm);
      chk("en_onehot", {mult_en_o, div_en_o, mult_sel_o, div_sel_o},
          {~vecs[i].f3[2], vecs[i].f3[2], ~vecs[i].f3[2], vecs[i].f3[2]});
      chk("issue_ctl", {multdiv_ready_id_o, busy_o, req_ready_o}, 3'b110);
      chk("operands", {op_a_o, op_b_o}, {vecs[i].a, vecs[i].b});
      wait_wb();
    end

    // Random ops against the ISA reference.
    for (int i = 0; i < 8; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i == 3) ? 32'h0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
      do_op(rf3, ra, rb, 5'(i + 1), 1'b1, ref_calc(rf3, ra, rb));
      wait_wb();
    end

    // Flush three cycles into a DIV: unit is drained, nothing written back.
    unit_lat = 8;
    do_op(3'b100, 32'd1000, 32'd3, 5'd20, 1'b0, 32'h0);
    repeat (2) @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    chk("drain_ctl", {div_en_o, div_sel_o, multdiv_ready_id_o, busy_o, req_ready_o}, 5'b11110);
    seen = 1'b0; t = 0;
    while (div_en_o && t < 50) begin
      @(negedge clk_i);
      if (wb_valid_o) seen = 1'b1;
      t++;
    end
    @(negedge clk_i);
    if (wb_valid_o) seen = 1'b1;
    chk("drain_no_wb", seen, 1'b0);
    chk("drain_done", {div_en_o, busy_o}, 2'b00);
    unit_lat = 3;
    do_op(3'b000, 32'd3, 32'd3, 5'd21, 1'b1, 32'd9);
    wait_wb();

    // Writeback back-pressure: result held stable, no new accept.
    wb_ready_i = 1'b0;
    do_op(3'b101, 32'd1000, 32'd10, 5'd22, 1'b1, 32'd100);
    t = 0;
    while (!wb_valid_o && t < 50) begin @(negedge clk_i); t++; end
    held = wb_data_o;
    chk("stall_first", held, 32'd100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("stall_hold", {wb_valid_o, req_ready_o, wb_data_o, wb_rd_o}, {2'b10, held, 5'd22});
    end
    wb_ready_i = 1'b1;
    wait_wb();

    // Flush in RESP drops the result.
    wb_ready_i = 1'b0;
    do_op(3'b000, 32'd4, 32'd4, 5'd23, 1'b0, 32'h0);
    t = 0;
    while (!wb_valid_o && t < 50) begin @(negedge clk_i); t++; end
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    wb_ready_i = 1'b1;
    chk("resp_flush", {busy_o, wb_valid_o}, 2'b00);

    // Intermediate registers: per-register enable, independent of flush.
    @(negedge clk_i);
    imd_val_d_i = {34'h2AAAA5555, 34'h112345678}; imd_val_we_i = 2'b01; flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    chk("imd_we0", imd_val_q_o, {34'h0, 34'h112345678});
    imd_val_we_i = 2'b10;
    @(posedge clk_i); #1;
    chk("imd_we1", imd_val_q_o, {34'h2AAAA5555, 34'h112345678});
    imd_val_d_i = '1; imd_val_we_i = 2'b00;
    @(posedge clk_i); #1;
    chk("imd_hold", imd_val_q_o, {34'h2AAAA5555, 34'h112345678});

    // Reset in the middle of ISSUE.
    unit_lat = 8;
    do_op(3'b110, 32'd77, 32'd5, 5'd24, 1'b0, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("midrst_ctl", {busy_o, req_ready_o, mult_en_o, div_en_o, div_sel_o, multdiv_ready_id_o}, 6'b0);
    chk("midrst_op", {operator_o, signed_mode_o, op_a_o, op_b_o}, 68'h0);
    chk("midrst_imd", imd_val_q_o, 68'h0);
    chk("midrst_wb", {wb_valid_o, wb_rd_o, wb_data_o}, 38'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    unit_lat = 3;

`ifdef IBEX_MULTDIV_RESULT_CACHE_EN
    do_op(3'b100, 32'd100, 32'd7, 5'd25, 1'b1, 32'd14);
    wait_wb();
    do_op(3'b100, 32'd100, 32'd7, 5'd26, 1'b1, 32'd14);
    chk("cache_hit", {wb_valid_o, div_en_o, multdiv_ready_id_o}, 3'b100);
    wait_wb();
`endif

    do_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd27, 1'b1, 32'h0);
    wait_wb();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
